// File: rtl/prim_clock_mux_ctrl_pkg.sv
// Shared types and helpers for the N-input clock mux sequencer.
package prim_clock_mux_ctrl_pkg;

    // Sequencer phases: break (GATE_OFF), commit (SWITCH), make (GATE_ON), handshake (DONE).
    typedef enum logic [2:0] {
        St_Idle    = 3'd0,
        St_GateOff = 3'd1,
        St_Switch  = 3'd2,
        St_GateOn  = 3'd3,
        St_Done    = 3'd4
    } clk_mux_ctrl_st_e;

    localparam int unsigned StatsW = 8;

    // One-hot encoding of idx; all-zero when idx is out of range for n sources.
    function automatic logic [31:0] onehot(input int unsigned idx, input int unsigned n);
        logic [31:0] res;
        res = '0;
        if (idx < n) res = 32'd1 << idx;
        return res;
    endfunction

endpackage

// File: rtl/prim_clock_mux_ctrl_cnt.sv
// Loadable settle down-counter: loads SettleCycles-1, decrements to zero, never wraps.
module prim_clock_mux_ctrl_cnt #(
    parameter  int unsigned SettleCycles = 3,
    localparam int unsigned CntW         = $clog2(SettleCycles + 1)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: reload on phase entry, otherwise step down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CntW'(SettleCycles - 1);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/prim_clock_mux_ctrl.sv
// Break-before-make sequencer for switching between NumClk gated clock sources.
// Optional switch statistics counter enabled by PRIM_CLOCK_MUX_CTRL_STATS_EN.
module prim_clock_mux_ctrl
    import prim_clock_mux_ctrl_pkg::*;
#(
    parameter  int unsigned NumClk       = 4,
    parameter  int unsigned SettleCycles = 3,
    parameter  int unsigned DefaultSel   = 0,
    localparam int unsigned SelW         = $clog2(NumClk)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic [SelW-1:0]   sel_i,
    output logic              ack_o,
    output logic              err_o,
    output logic              busy_o,
    output logic [SelW-1:0]   sel_o,
    output logic [NumClk-1:0] clk_en_o
`ifdef PRIM_CLOCK_MUX_CTRL_STATS_EN
    ,
    output logic [StatsW-1:0] switch_cnt_o
`endif
);

    clk_mux_ctrl_st_e state_q, state_d;
    logic [SelW-1:0]  sel_q, sel_d;
    logic [SelW-1:0]  pend_q, pend_d;
    logic             err_q, err_d;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic             sel_valid;

    assign sel_valid = (32'(sel_i) < NumClk);

    prim_clock_mux_ctrl_cnt #(
        .SettleCycles(SettleCycles)
    ) u_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (cnt_load),
        .dec_i  (cnt_dec),
        .zero_o (cnt_zero)
    );

    // Next-state logic: requests are only looked at in IDLE; later ones are dropped.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        pend_d   = pend_q;
        err_d    = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            St_Idle: begin
                if (req_i) begin
                    if (!sel_valid) begin
                        err_d = 1'b1;
                    end else if (sel_i == sel_q) begin
                        state_d = St_Done;
                    end else begin
                        pend_d   = sel_i;
                        cnt_load = 1'b1;
                        state_d  = St_GateOff;
                    end
                end
            end
            St_GateOff: begin
                if (cnt_zero) state_d = St_Switch;
                else          cnt_dec = 1'b1;
            end
            St_Switch: begin
                sel_d    = pend_q;
                cnt_load = 1'b1;
                state_d  = St_GateOn;
            end
            St_GateOn: begin
                if (cnt_zero) state_d = St_Done;
                else          cnt_dec = 1'b1;
            end
            St_Done: begin
                state_d = St_Idle;
            end
            default: begin
                state_d = St_Idle;
            end
        endcase
    end

    // State, committed select, pending target and error pulse registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= St_Idle;
            sel_q   <= SelW'(DefaultSel);
            pend_q  <= SelW'(DefaultSel);
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

`ifdef PRIM_CLOCK_MUX_CTRL_STATS_EN
    logic [StatsW-1:0] switch_cnt_q;

    // Saturating count of committed switches (one per SWITCH cycle).
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            switch_cnt_q <= '0;
        end else if ((state_q == St_Switch) && (switch_cnt_q != '1)) begin
            switch_cnt_q <= switch_cnt_q + StatsW'(1);
        end
    end

    assign switch_cnt_o = switch_cnt_q;
`endif

    // Enables are forced off across the break phase and the commit cycle.
    assign clk_en_o = ((state_q == St_GateOff) || (state_q == St_Switch))
                      ? '0 : NumClk'(onehot(32'(sel_q), NumClk));
    assign busy_o   = (state_q == St_GateOff) || (state_q == St_Switch) ||
                      (state_q == St_GateOn);
    assign ack_o    = (state_q == St_Done);
    assign err_o    = err_q;
    assign sel_o    = sel_q;

    a_en_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(clk_en_o));
    a_sel_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q != St_Switch) |=> $stable(sel_q));
    a_sel_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
        req_i |-> !$isunknown(sel_i));

endmodule
